// File: rtl/fp_div_pkg.sv
// Shared types and encodings for the iterative floating-point divider.
// Rounding mode selected by FP_DIV_ROUND_NEAREST_EN (default: truncate).
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_t;

  localparam int FLG_INV = 3;
  localparam int FLG_DBZ = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Encodings are built 64 bits wide; callers size-cast to their word.
  function automatic logic [63:0] qnan_enc(input int ew, input int mw);
    logic [63:0] v;
    v = (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    return v;
  endfunction

  function automatic logic [63:0] inf_enc(
    input logic s,
    input int   ew,
    input int   mw
  );
    logic [63:0] v;
    v = (64'(s) << (ew + mw)) | (((64'd1 << ew) - 64'd1) << mw);
    return v;
  endfunction

  function automatic logic [63:0] zero_enc(
    input logic s,
    input int   ew,
    input int   mw
  );
    logic [63:0] v;
    v = 64'(s) << (ew + mw);
    return v;
  endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Operand decoder: zero/inf/nan class, sign, exponent, mantissa.
// Subnormals are reported as zero.
module fp_div_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       man
);

  logic exp_ones;
  logic exp_zero;
  logic frac_zero;

  assign sign      = x[EXP_W+MAN_W];
  assign exp       = x[EXP_W+MAN_W-1:MAN_W];
  assign exp_ones  = &exp;
  assign exp_zero  = ~|exp;
  assign frac_zero = ~|x[MAN_W-1:0];

  assign is_zero = exp_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_nan  = exp_ones & ~frac_zero;
  assign man     = {1'b1, x[MAN_W-1:0]};

endmodule

// File: rtl/fp_div_iter.sv
// Iterative radix-2 restoring floating-point divider with valid/ready ports.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; else truncate.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(QW);

  localparam logic signed [XW-1:0] BIAS = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE  = XW'(1);
  localparam logic [W-1:0] QNAN = W'(qnan_enc(EXP_W, MAN_W));

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  logic             zero_a, inf_a, nan_a, sign_a;
  logic             zero_b, inf_b, nan_b, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   man_a, man_b;

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x       (a),
    .is_zero (zero_a),
    .is_inf  (inf_a),
    .is_nan  (nan_a),
    .sign    (sign_a),
    .exp     (exp_a),
    .man     (man_a)
  );

  fp_div_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x       (b),
    .is_zero (zero_b),
    .is_inf  (inf_b),
    .is_nan  (nan_b),
    .sign    (sign_b),
    .exp     (exp_b),
    .man     (man_b)
  );

  state_t state_q, state_d;

  logic [MAN_W+1:0]       rem_q;
  logic [MAN_W:0]         div_q;
  logic [QW-1:0]          quo_q;
  logic [CW-1:0]          cnt_q;
  logic signed [XW-1:0]   exp_q;
  logic                   sign_q;
  logic [W-1:0]           result_q;
  logic [3:0]             flags_q;

  logic accept;
  logic special;
  logic sign_n;
  logic last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign accept    = in_valid & in_ready;
  assign sign_n    = sign_a ^ sign_b;
  assign special   = zero_a | inf_a | nan_a | zero_b | inf_b | nan_b;
  assign last      = (cnt_q == CW'(QW - 1));

  logic [W-1:0] spec_res;
  logic [3:0]   spec_flg;

  always_comb begin
    spec_res = W'(zero_enc(sign_n, EXP_W, MAN_W));
    spec_flg = '0;
    if (nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b)) begin
      spec_res          = QNAN;
      spec_flg[FLG_INV] = 1'b1;
    end else if (inf_a) begin
      spec_res = W'(inf_enc(sign_n, EXP_W, MAN_W));
    end else if (zero_b) begin
      spec_res          = W'(inf_enc(sign_n, EXP_W, MAN_W));
      spec_flg[FLG_DBZ] = 1'b1;
    end
  end

  // One restoring step: subtract if it fits, then shift the remainder.
  logic [MAN_W+2:0] diff;
  logic             q_bit;
  logic [MAN_W+1:0] rem_nx;

  assign diff   = {1'b0, rem_q} - {2'b00, div_q};
  assign q_bit  = ~diff[MAN_W+2];
  assign rem_nx = q_bit ? diff[MAN_W+1:0] : rem_q;

  logic                 lead;
  logic [QW-1:0]        qn;
  logic signed [XW-1:0] en;
  logic signed [XW-1:0] er;
  logic                 sticky;
  logic                 inc;
  logic [MAN_W+1:0]     mant_r;
  logic                 carry;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         norm_res;
  logic [3:0]           norm_flg;

  assign lead   = quo_q[QW-1];
  assign qn     = lead ? quo_q : {quo_q[QW-2:0], 1'b0};
  assign en     = lead ? exp_q : exp_q - ONE;
  assign sticky = |rem_q;
  assign inc    = RNE & qn[1] & (qn[0] | sticky | qn[2]);
  assign mant_r = {1'b0, qn[QW-1:2]} + {{(MAN_W+1){1'b0}}, inc};
  assign carry  = mant_r[MAN_W+1];
  assign frac   = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  assign er     = en + $signed({{(XW-1){1'b0}}, carry});

  always_comb begin
    norm_res = {sign_q, er[EXP_W-1:0], frac};
    norm_flg = '0;
    if (er >= EMAX) begin
      norm_res          = W'(inf_enc(sign_q, EXP_W, MAN_W));
      norm_flg[FLG_OVF] = 1'b1;
    end else if (er <= $signed(XW'(0))) begin
      norm_res          = W'(zero_enc(sign_q, EXP_W, MAN_W));
      norm_flg[FLG_UNF] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = special ? DONE : DIVIDE;
      DIVIDE: if (last) state_d = NORM;
      NORM:   state_d = DONE;
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept) begin
      rem_q  <= {1'b0, man_a};
      div_q  <= man_b;
      quo_q  <= '0;
      cnt_q  <= '0;
      exp_q  <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS;
      sign_q <= sign_n;
      if (special) begin
        result_q <= spec_res;
        flags_q  <= spec_flg;
      end
    end else if (state_q == DIVIDE) begin
      rem_q <= rem_nx << 1;
      quo_q <= {quo_q[QW-2:0], q_bit};
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == NORM) begin
      result_q <= norm_res;
      flags_q  <= norm_flg;
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter (single precision defaults).
// Vector table, handshake/reset corner sequences, randomized model check.
module tb_fp_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: real quotient via integer division of the significands.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f,
                                output int lat);
    logic    s;
    int      ex, ey, e, sh;
    logic    zx, zy, ix, iy, nx, ny;
    longint  ma, mb, num, q, rm, mant, low, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    f   = 4'b0000;
    lat = 1;
    r   = {s, 31'h0};
    if (nx || ny || (zx && zy) || (ix && iy)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (ix) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zy) begin
      r = {s, 8'hFF, 23'h0};
      f = 4'b0100;
    end else if (iy || zx) begin
      r = {s, 31'h0};
    end else begin
      lat  = 28;
      ma   = longint'({1'b1, x[22:0]});
      mb   = longint'({1'b1, y[22:0]});
      num  = ma << 25;
      q    = num / mb;
      rm   = num % mb;
      sh   = (q >= (longint'(1) << 25)) ? 2 : 1;
      e    = ex - ey + 127 - ((sh == 1) ? 1 : 0);
      mant = q >> sh;
      low  = q & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
`ifdef FP_DIV_ROUND_NEAREST_EN
      if (low > half || (low == half && (rm != 0 || mant[0]))) begin
        mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
          mant = mant >> 1;
          e    = e + 1;
        end
      end
`else
      if (low < 0 || rm < 0 || half < 0) e = -1000;
`endif
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0001;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  task automatic start(input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(n < 100), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    check("valid_wait", 64'(out_valid), 64'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y,
                     output logic [31:0] r, output logic [3:0] f,
                     output int lat);
    start(x, y);
    wait_valid(lat);
    r = result;
    f = flags;
    ack();
  endtask

  initial begin
    logic [31:0] r, er, ra, rb;
    logic [3:0]  f, ef;
    int          lat, elat;
    logic        seen;
    logic [31:0] specials[7];

    vecs.push_back('{32'h3FC00000, 32'h3F400000, 32'h40000000, 4'b0000, 28});
`ifdef FP_DIV_ROUND_NEAREST_EN
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28});
`else
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28});
`endif
    vecs.push_back('{32'hC0000000, 32'h00000000, 32'hFF800000, 4'b0100, 1});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 28});
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1});
    vecs.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1});
    vecs.push_back('{32'h40C00000, 32'hC0000000, 32'hC0400000, 4'b0000, 28});
    vecs.push_back('{32'h3F800000, 32'h00400000, 32'h7F800000, 4'b0100, 1});
    vecs.push_back('{32'h7F800000, 32'h80000000, 32'hFF800000, 4'b0000, 1});

    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'h00000123, 32'h3F800000};

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].r));
      check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].f));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    start(32'h3FC00000, 32'h3F400000);
    wait_valid(lat);
    r = result;
    f = flags;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_stable", {28'h0, out_valid, in_ready, f, r},
            {28'h0, 1'b1, 1'b0, 4'b0000, 32'h40000000});
      check("hold_now", {32'h0, result}, {32'h0, r});
      check("hold_flags", 64'(flags), 64'(f));
    end
    ack();
    check("ack_in_ready", 64'(in_ready), 64'd1);
    check("ack_out_valid", 64'(out_valid), 64'd0);

    start(32'h3F800000, 32'h40400000);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run(32'h40C00000, 32'hC0000000, r, f, lat);
    check("post_abort_result", 64'(r), 64'hC0400000);
    check("post_abort_latency", 64'(lat), 64'd28);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(7) == 0) begin
        ra = specials[$urandom_range(6)];
      end else if ($urandom_range(1) == 0) begin
        ra = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      end else begin
        ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end
      if ($urandom_range(7) == 0) begin
        rb = specials[$urandom_range(6)];
      end else if ($urandom_range(1) == 0) begin
        rb = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      end else begin
        rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end
      model(ra, rb, er, ef, elat);
      run(ra, rb, r, f, lat);
      check($sformatf("rand_%08h_%08h_result", ra, rb), 64'(r), 64'(er));
      check($sformatf("rand_%08h_%08h_flags", ra, rb), 64'(f), 64'(ef));
      check($sformatf("rand_%08h_%08h_latency", ra, rb), 64'(lat),
            64'(elat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
